ram_bank: RTL and testbench

RAM_BANK -- requirements
Module: ram_bank

---
 rtl/ram_bank_pkg.sv | 18 +
 rtl/ram_bank_parity.sv | 19 +
 rtl/ram_bank.sv | 150 +++++++++++++++
 tb/tb_ram_bank.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ram_bank_pkg.sv
// Shared constants and types for the ram_bank word-addressed memory bank.
// Optional byte parity is enabled by defining RAM_BANK_PARITY_EN.
package ram_bank_pkg;

    localparam logic        RstEnable    = 1'b0;
    localparam logic        RstDisable   = 1'b1;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam int          DefaultDataW = 32;
    localparam int          DefaultDepth = 4096;
    localparam int          DefaultAddrW = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/ram_bank_parity.sv
// Even-parity generator: one bit per byte lane, set when the byte has an odd
// number of ones so that byte plus parity bit always carries an even count.
module ram_bank_parity
    import ram_bank_pkg::*;
#(
    parameter int DATA_W = DefaultDataW
) (
    input  logic [DATA_W-1:0]   data_i,
    output logic [DATA_W/8-1:0] parity_o
);

    always_comb begin
        parity_o = '0;
        for (int b = 0; b < DATA_W / 8; b++) begin
            parity_o[b] = ^data_i[8*b +: 8];
        end
    end

endmodule

// File: rtl/ram_bank.sv
// Single-port RAM bank with self-zeroing INIT phase, byte-lane writes and a
// registered one-cycle response. RAM_BANK_PARITY_EN adds per-byte parity.
module ram_bank
    import ram_bank_pkg::*;
#(
    parameter int DATA_W = DefaultDataW,
    parameter int DEPTH  = DefaultDepth,
    parameter int ADDR_W = DefaultAddrW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] sel_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   data_i,
    output logic                ready_o,
    output logic                ack_o,
    output logic [DATA_W-1:0]   data_o,
    output logic                err_o
);

    localparam int LANES = DATA_W / 8;
    localparam int LSB   = $clog2(LANES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(LANES - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

    state_e            state_q;
    logic [IDX_W-1:0]  init_cnt_q;
    logic              ready_q;

    logic              ack_q, ack_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic [IDX_W-1:0]  idx;
    logic              addr_err;
    logic              accept;
    logic              do_write;
    logic [DATA_W-1:0] rd_word;

    // Shifting instead of slicing keeps the decode valid when LSB is zero.
    assign word_idx = addr_i >> LSB;
    assign idx      = word_idx[IDX_W-1:0];
    assign addr_err = (|(addr_i & LANE_MASK)) || (word_idx >= DEPTH_A);
    assign accept   = req_i && ready_q;
    assign do_write = accept && (we_i == WriteEnable) && !addr_err;
    assign rd_word  = mem_q[idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == LAST_IDX) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                ST_RUN:  ready_q <= 1'b1;
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // NOTE: the array has no reset branch; it is cleared by the INIT sweep,
    // which lets it map onto block RAM instead of thousands of flops.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[init_cnt_q] <= '0;
        end else if (do_write) begin
            for (int b = 0; b < LANES; b++) begin
                if (sel_i[b]) mem_q[idx][8*b +: 8] <= data_i[8*b +: 8];
            end
        end
    end

`ifdef RAM_BANK_PARITY_EN
    logic [LANES-1:0] par_q [DEPTH];
    logic [LANES-1:0] wr_par;
    logic [LANES-1:0] rd_par;

    ram_bank_parity #(.DATA_W(DATA_W)) u_wr_parity (
        .data_i   (data_i),
        .parity_o (wr_par)
    );

    ram_bank_parity #(.DATA_W(DATA_W)) u_rd_parity (
        .data_i   (rd_word),
        .parity_o (rd_par)
    );

    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            par_q[init_cnt_q] <= '0;
        end else if (do_write) begin
            for (int b = 0; b < LANES; b++) begin
                if (sel_i[b]) par_q[idx][b] <= wr_par[b];
            end
        end
    end
`endif

    // NOTE: every always_comb output gets a default first so no path
    // leaves a value held, which would otherwise infer a latch.
    always_comb begin
        ack_d  = accept;
        data_d = DATA_W'(ZeroWord);
        err_d  = 1'b0;
        if (accept) begin
            if (addr_err) begin
                err_d = 1'b1;
            end else if (we_i != WriteEnable) begin
                data_d = rd_word;
`ifdef RAM_BANK_PARITY_EN
                err_d  = (rd_par != par_q[idx]);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q  <= 1'b0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            ack_q  <= ack_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign ready_o = ready_q;
    assign ack_o   = ack_q;
    assign data_o  = data_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank: vector table for single accesses, plus
// hand-written sequences for back-to-back access and reset during INIT/RUN.
module tb_ram_bank;
    import ram_bank_pkg::*;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        ready_o;
    logic        ack_o;
    logic [31:0] data_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    ram_bank #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_i),
        .we_i    (we_i),
        .sel_i   (sel_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .ack_o   (ack_o),
        .data_o  (data_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One request driven at the falling edge, sampled 1ns after acceptance.
    task automatic do_req(input logic we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        req_i  = 1'b1;
        we_i   = we;
        sel_i  = sel;
        addr_i = addr;
        data_i = data;
        @(posedge clk);
        #1;
        req_i  = 1'b0;
    endtask

    // Call right after reset release on a falling edge; counts rising edges
    // until ready_o is seen high, bounded so a stuck bank cannot hang the run.
    task automatic wait_ready(input string name);
        int n = 0;
        while (ready_o !== 1'b1 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, n, DEPTH);
    endtask

    task automatic check_resp(input string name, input logic [31:0] exp_data, input logic exp_err);
        check({name, ".ack"},  {31'd0, ack_o}, 32'd1);
        check({name, ".data"}, data_o, exp_data);
        check({name, ".err"},  {31'd0, err_o}, {31'd0, exp_err});
    endtask

    initial begin
        vecs[0]  = '{"rd_last_word",   1'b0, 4'hF, 32'h0000_0FFC, 32'h0,         32'h0000_0000, 1'b0};
        vecs[1]  = '{"wr_full",        1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[2]  = '{"wr_lane0",       1'b1, 4'h1, 32'h0000_0010, 32'h0000_00AA, 32'h0000_0000, 1'b0};
        vecs[3]  = '{"rd_merged",      1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEAA, 1'b0};
        vecs[4]  = '{"rd_misaligned",  1'b0, 4'hF, 32'h0000_0012, 32'h0,         32'h0000_0000, 1'b1};
        vecs[5]  = '{"rd_oob",         1'b0, 4'hF, 32'h0000_4000, 32'h0,         32'h0000_0000, 1'b1};
        vecs[6]  = '{"wr_misaligned",  1'b1, 4'hF, 32'h0000_0012, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[7]  = '{"rd_after_mis",   1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_BEAA, 1'b0};
        vecs[8]  = '{"wr_oob",         1'b1, 4'hF, 32'h0000_4000, 32'h1111_1111, 32'h0000_0000, 1'b1};
        vecs[9]  = '{"rd_word0",       1'b0, 4'hF, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};
        vecs[10] = '{"wr_sel_none",    1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[11] = '{"rd_after_none",  1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEAA, 1'b0};
        vecs[12] = '{"wr_lanes_1010",  1'b1, 4'hA, 32'h0000_0010, 32'h1122_3344, 32'h0000_0000, 1'b0};
        vecs[13] = '{"rd_lanes_1010",  1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'h11AD_33AA, 1'b0};
        vecs[14] = '{"rd_last_again",  1'b0, 4'hF, 32'h0000_0FFC, 32'h0,         32'h0000_0000, 1'b0};

        rst = RstEnable;
        req_i = 1'b0; we_i = 1'b0; sel_i = '0; addr_i = '0; data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.ready", {31'd0, ready_o}, 32'd0);
        check("reset.ack",   {31'd0, ack_o},   32'd0);
        check("reset.data",  data_o,           32'd0);
        check("reset.err",   {31'd0, err_o},   32'd0);

        @(negedge clk);
        rst = RstDisable;
        wait_ready("init_cycles");

        for (int i = 0; i < 15; i++) begin
            do_req(vecs[i].we, vecs[i].sel, vecs[i].addr, vecs[i].data);
            check_resp(vecs[i].name, vecs[i].exp_data, vecs[i].exp_err);
        end

        // Write then read of the same word on consecutive cycles.
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; sel_i = 4'hF; addr_i = 32'h20; data_i = 32'h1234_5678;
        @(posedge clk);
        #1;
        check_resp("b2b_wr", 32'h0, 1'b0);
        @(negedge clk);
        we_i = 1'b0;
        @(posedge clk);
        #1;
        req_i = 1'b0;
        check_resp("b2b_rd", 32'h1234_5678, 1'b0);
        @(posedge clk);
        #1;
        check("b2b_ack_drop",  {31'd0, ack_o}, 32'd0);
        check("b2b_data_idle", data_o,         32'd0);

`ifdef RAM_BANK_PARITY_EN
        dut.mem_q[8] = dut.mem_q[8] ^ 32'h0000_0008;
        do_req(1'b0, 4'hF, 32'h20, 32'h0);
        check_resp("parity_flip", 32'h1234_5670, 1'b1);
`endif

        // Reset pulse at INIT count 100, with an ignored request beforehand.
        @(negedge clk);
        rst = RstEnable;
        @(negedge clk);
        rst = RstDisable;
        repeat (100) @(posedge clk);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10;
        @(posedge clk);
        #1;
        req_i = 1'b0;
        check("init_req_ignored", {31'd0, ack_o}, 32'd0);
        @(negedge clk);
        rst = RstEnable;
        #1;
        check("init_rst.ready", {31'd0, ready_o}, 32'd0);
        @(negedge clk);
        rst = RstDisable;
        wait_ready("init_restart_cycles");

        // Reset pulse while a write ack is showing.
        do_req(1'b1, 4'hF, 32'h10, 32'hCAFE_F00D);
        check("run_pending_ack", {31'd0, ack_o}, 32'd1);
        rst = RstEnable;
        #1;
        check("run_rst.ack",   {31'd0, ack_o},   32'd0);
        check("run_rst.ready", {31'd0, ready_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = RstDisable;
        #1;
        check("run_rst.no_ack", {31'd0, ack_o}, 32'd0);
        wait_ready("run_restart_cycles");

        do_req(1'b0, 4'hF, 32'h10, 32'h0);
        check_resp("rezeroed_0x10", 32'h0, 1'b0);
        do_req(1'b0, 4'hF, 32'h20, 32'h0);
        check_resp("rezeroed_0x20", 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
